exp7_unidade_controle: RTL
==========================

Name: exp7_unidade_controle

Overview:
- Moore control unit for the memory-sequence game ("Experiencia 7").
- Sits directly upstream of the game datapath (exp7_fluxo_dados): drives all its control strobes and consumes its status flags.
- Each round, the player repeats the stored sequence. On success the player enters one new move, which is written into the RAM, and the round counter advances.
- The unit also generates the end-of-game status: win, loss by error, loss by timeout.

Parameters:
- None. State encoding is fixed and visible on db_estado.

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; forces state inicial
- iniciar  in  1  start/restart request, level-sampled
- jogada_feita  in  1  one-cycle pulse from the datapath edge detector
- jogada_correta  in  1  RAM data equals registered jogada
- enderecoIgualRodada  in  1  address counter equals round counter
- fimL  in  1  round counter at 15 (rco)
- timeout  in  1  timeout counter terminal count
- zeraCR, zeraE, contaCR, contaE  out  1 each  counter clears/enables
- limpaRC, registraRC  out  1 each  jogada register clear/load
- zeraLeds, registraLeds, led_selector  out  1 each  LED source register control
- contaT  out  1  timeout counter enable
- ram_enable  out  1  RAM write enable
- pronto, ganhou, perdeu, db_timeout  out  1 each  end-of-game status
- db_estado  out  4  current state code

Behaviour:
- Reset:
  - Asynchronous; state returns to inicial (4'h0) immediately, including mid-round and mid-write.
  - All outputs are 0 in inicial.
- Output style: pure Moore decode of state. Every output not listed for a state is 0.
- States, active outputs and transitions:
  - inicial 0: no outputs. iniciar -> preparacao.
  - preparacao 1: zeraCR, zeraE, limpaRC, zeraLeds. -> inicio_rodada.
  - inicio_rodada 2: zeraE. -> espera_jogada.
  - espera_jogada 3: contaT.
    - jogada_feita -> registra.
    - else timeout -> fim_timeout.
    - else stay.
  - registra 4: registraRC. -> comparacao.
  - comparacao 5: no outputs.
    - !jogada_correta -> fim_errou.
    - else enderecoIgualRodada -> ultima_jogada.
    - else -> proxima_jogada.
  - proxima_jogada 6: contaE. -> espera_jogada.
  - ultima_jogada 7: no outputs.
    - fimL -> fim_acertou.
    - else -> avanca_endereco.
  - avanca_endereco F: contaE. -> espera_escrita. The address is now rodada+1.
  - espera_escrita 8: contaT.
    - jogada_feita -> registra_escrita.
    - else timeout -> fim_timeout.
    - else stay.
  - registra_escrita 9: registraRC. -> escreve.
  - escreve A: ram_enable (exactly one cycle). -> proxima_rodada.
  - proxima_rodada B: contaCR. -> inicio_rodada.
  - fim_acertou C: pronto, ganhou, registraLeds, led_selector.
  - fim_timeout D: pronto, perdeu, db_timeout, registraLeds, led_selector.
  - fim_errou E: pronto, perdeu, registraLeds, led_selector.
  - In all three fim states: iniciar -> preparacao, else stay.
- Simultaneous events:
  - jogada_feita and timeout high in the same cycle: the jogada wins.
  - iniciar in any non-idle, non-fim state is ignored.
- Latency:
  - Press pulse to RAM compare: 2 cycles (registra, comparacao).
  - Correct final press to new-round address zeroing: avanca_endereco, espera_escrita(n), registra_escrita, escreve, proxima_rodada, inicio_rodada.
- Round 15: fimL at ultima_jogada wins without a write. The round counter never wraps.
- Unused codes: none. All 16 codes are assigned.

Test Plan:
- Reset assert mid-espera_jogada (db_estado=3) -> db_estado=0 asynchronously, all outputs 0. Reset release with iniciar=0 -> stays 0.
- iniciar pulse, then one correct press in round 0, new move entered -> state sequence 0,1,2,3,4,5,7,F,8,9,A,B,2. ram_enable high exactly one cycle in A. contaCR high one cycle.
- Round 1 with wrong first press (jogada_correta=0 at comparacao) -> reaches E with pronto=1, perdeu=1, ganhou=0. iniciar -> 1.
- In espera_jogada, timeout=1 with jogada_feita=0 -> D: db_timeout=1, perdeu=1. Same cycle with jogada_feita=1 -> 4.
- In comparacao with jogada_correta=1, enderecoIgualRodada=1, then fimL=1 -> 7, then C with ganhou=1, ram_enable never asserted.
- Timeout during espera_escrita -> D. Checking contaT is high only in states 3 and 8 across a full two-round run.

Source files
------------

// File: rtl/exp7_unidade_controle.sv
// Moore control unit for the memory-sequence game.
// Drives every control strobe of exp7_fluxo_dados and decodes the end-of-game status.
//
// Ports:
//   clock, reset         system clock, asynchronous active-high reset (forces inicial)
//   iniciar              start/restart request, level-sampled
//   jogada_feita         one-cycle press pulse from the datapath edge detector
//   jogada_correta       RAM data equals registered jogada
//   enderecoIgualRodada  address counter equals round counter
//   fimL                 round counter at its last round
//   timeout              timeout counter terminal count
//   zeraCR/zeraE/contaCR/contaE        round and address counter clears/enables
//   limpaRC/registraRC                 jogada register clear/load
//   zeraLeds/registraLeds/led_selector LED source register control
//   contaT                             timeout counter enable
//   ram_enable                         RAM write enable
//   pronto/ganhou/perdeu/db_timeout    end-of-game status
//   db_estado                          current state code
module exp7_unidade_controle (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       jogada_correta,
  input  logic       enderecoIgualRodada,
  input  logic       fimL,
  input  logic       timeout,
  output logic       zeraCR,
  output logic       zeraE,
  output logic       contaCR,
  output logic       contaE,
  output logic       limpaRC,
  output logic       registraRC,
  output logic       zeraLeds,
  output logic       registraLeds,
  output logic       led_selector,
  output logic       contaT,
  output logic       ram_enable,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    StInicial         = 4'h0,
    StPreparacao      = 4'h1,
    StInicioRodada    = 4'h2,
    StEsperaJogada    = 4'h3,
    StRegistra        = 4'h4,
    StComparacao      = 4'h5,
    StProximaJogada   = 4'h6,
    StUltimaJogada    = 4'h7,
    StEsperaEscrita   = 4'h8,
    StRegistraEscrita = 4'h9,
    StEscreve         = 4'hA,
    StProximaRodada   = 4'hB,
    StFimAcertou      = 4'hC,
    StFimTimeout      = 4'hD,
    StFimErrou        = 4'hE,
    StAvancaEndereco  = 4'hF
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StInicial;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    zeraCR       = 1'b0;
    zeraE        = 1'b0;
    contaCR      = 1'b0;
    contaE       = 1'b0;
    limpaRC      = 1'b0;
    registraRC   = 1'b0;
    zeraLeds     = 1'b0;
    registraLeds = 1'b0;
    led_selector = 1'b0;
    contaT       = 1'b0;
    ram_enable   = 1'b0;
    pronto       = 1'b0;
    ganhou       = 1'b0;
    perdeu       = 1'b0;
    db_timeout   = 1'b0;

    case (state_q)
      StInicial: begin
        if (iniciar) state_d = StPreparacao;
      end
      StPreparacao: begin
        zeraCR   = 1'b1;
        zeraE    = 1'b1;
        limpaRC  = 1'b1;
        zeraLeds = 1'b1;
        state_d  = StInicioRodada;
      end
      StInicioRodada: begin
        zeraE   = 1'b1;
        state_d = StEsperaJogada;
      end
      StEsperaJogada: begin
        contaT = 1'b1;
        // A press arriving with the terminal count still counts as a press.
        if (jogada_feita)  state_d = StRegistra;
        else if (timeout)  state_d = StFimTimeout;
      end
      StRegistra: begin
        registraRC = 1'b1;
        state_d    = StComparacao;
      end
      StComparacao: begin
        if (!jogada_correta)          state_d = StFimErrou;
        else if (enderecoIgualRodada) state_d = StUltimaJogada;
        else                          state_d = StProximaJogada;
      end
      StProximaJogada: begin
        contaE  = 1'b1;
        state_d = StEsperaJogada;
      end
      StUltimaJogada: begin
        // Last round is won outright; no new move is written.
        if (fimL) state_d = StFimAcertou;
        else      state_d = StAvancaEndereco;
      end
      StAvancaEndereco: begin
        contaE  = 1'b1;
        state_d = StEsperaEscrita;
      end
      StEsperaEscrita: begin
        contaT = 1'b1;
        if (jogada_feita)  state_d = StRegistraEscrita;
        else if (timeout)  state_d = StFimTimeout;
      end
      StRegistraEscrita: begin
        registraRC = 1'b1;
        state_d    = StEscreve;
      end
      StEscreve: begin
        ram_enable = 1'b1;
        state_d    = StProximaRodada;
      end
      StProximaRodada: begin
        contaCR = 1'b1;
        state_d = StInicioRodada;
      end
      StFimAcertou: begin
        pronto       = 1'b1;
        ganhou       = 1'b1;
        registraLeds = 1'b1;
        led_selector = 1'b1;
        if (iniciar) state_d = StPreparacao;
      end
      StFimTimeout: begin
        pronto       = 1'b1;
        perdeu       = 1'b1;
        db_timeout   = 1'b1;
        registraLeds = 1'b1;
        led_selector = 1'b1;
        if (iniciar) state_d = StPreparacao;
      end
      StFimErrou: begin
        pronto       = 1'b1;
        perdeu       = 1'b1;
        registraLeds = 1'b1;
        led_selector = 1'b1;
        if (iniciar) state_d = StPreparacao;
      end
      default: state_d = StInicial;
    endcase
  end

  assign db_estado = state_q;

endmodule
